// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline sequencer: FSM states, forwarding
// select codes, the PC register number and the scoreboard slot layout.
package pipeline_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LU_STALL = 2'b01,
        ST_MEM_WAIT = 2'b10
    } seq_state_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
    localparam logic [1:0] FWD_WB    = 2'b11;

    localparam logic [3:0] REG_PC = 4'd15;

    typedef struct packed {
        logic       valid;
        logic [3:0] rd;
        logic       wr;
        logic       load;
        logic       mem;
    } sb_slot_t;

    localparam sb_slot_t SLOT_EMPTY = '0;

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding select for one ID source register; the youngest
// writing slot wins and the PC register is always read from the regfile.
module fwd_select
    import pipeline_pkg::*;
(
    input  logic [3:0] i_src,
    input  logic       i_ex_wr,
    input  logic [3:0] i_ex_rd,
    input  logic       i_mem_wr,
    input  logic [3:0] i_mem_rd,
    input  logic       i_wb_wr,
    input  logic [3:0] i_wb_rd,
    output logic [1:0] o_sel
);

    always_comb begin
        o_sel = FWD_RF;
        if (i_src != REG_PC) begin
            if (i_ex_wr && (i_ex_rd == i_src)) begin
                o_sel = FWD_EXMEM;
            end else if (i_mem_wr && (i_mem_rd == i_src)) begin
                o_sel = FWD_MEMWB;
            end else if (i_wb_wr && (i_wb_rd == i_src)) begin
                o_sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline hazard sequencer: EX/MEM/WB scoreboard, load-use stall, branch
// flush, data-memory wait with timeout, and operand forwarding selects.
module pipeline_sequencer
    import pipeline_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       id_valid,
    input  logic [3:0] id_rn,
    input  logic [3:0] id_rm,
    input  logic [3:0] id_rd,
    input  logic       id_uses_rn,
    input  logic       id_uses_rm,
    input  logic       id_rf_enable,
    input  logic       id_load_instr,
    input  logic       id_mem_enable,
    input  logic       ex_branch_taken,
    input  logic       mem_ready,
    output logic       pc_enable,
    output logic       ifid_enable,
    output logic       idex_enable,
    output logic       exmem_enable,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       mem_req,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       mem_err
);

    localparam int unsigned     CNT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

    seq_state_t       r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_branch_pend;
    logic             r_mem_err;
    sb_slot_t         r_ex;
    sb_slot_t         r_mem;
    sb_slot_t         r_wb;

    logic     w_mem_req;
    logic     w_timeout;
    logic     w_freeze;
    logic     w_branch;
    logic     w_rn_hit;
    logic     w_rm_hit;
    logic     w_load_use;
    sb_slot_t w_id_slot;
    logic     w_unused;

    // The cycle that reaches the timeout behaves like a mem_ready cycle:
    // the pipeline advances and mem_err is latched at its closing edge.
    assign w_mem_req  = r_mem.valid & r_mem.mem;
    assign w_timeout  = (r_state == ST_MEM_WAIT) && (r_wait_cnt >= CNT_MAX);
    assign w_freeze   = w_mem_req & ~mem_ready & ~w_timeout;
    assign w_branch   = ~w_freeze & (ex_branch_taken | r_branch_pend);
    assign w_rn_hit   = id_uses_rn && (id_rn == r_ex.rd);
    assign w_rm_hit   = id_uses_rm && (id_rm == r_ex.rd);
    assign w_load_use = ~w_freeze & ~w_branch & id_valid & r_ex.valid
                      & r_ex.load & (w_rn_hit | w_rm_hit);

    assign w_id_slot = '{valid: id_valid, rd: id_rd, wr: id_rf_enable,
                         load: id_load_instr, mem: id_mem_enable};

    assign pc_enable    = ~w_freeze & ~w_load_use;
    assign ifid_enable  = ~w_freeze & ~w_load_use;
    assign idex_enable  = ~w_freeze;
    assign exmem_enable = ~w_freeze;
    assign ifid_flush   = w_branch;
    assign idex_bubble  = w_branch | w_load_use;
    assign mem_req      = w_mem_req;
    assign mem_err      = r_mem_err;

    assign w_unused = ^{r_mem.load, r_wb.load, r_wb.mem};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= '0;
            r_branch_pend <= 1'b0;
            r_mem_err     <= 1'b0;
            r_ex          <= SLOT_EMPTY;
            r_mem         <= SLOT_EMPTY;
            r_wb          <= SLOT_EMPTY;
        end else if (w_freeze) begin
            r_state       <= ST_MEM_WAIT;
            r_branch_pend <= r_branch_pend | ex_branch_taken;
            if (r_state != ST_MEM_WAIT) begin
                r_wait_cnt <= CNT_W'(1);
            end else if (r_wait_cnt != CNT_MAX) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
        end else begin
            r_state       <= w_load_use ? ST_LU_STALL : ST_RUN;
            r_wait_cnt    <= '0;
            r_branch_pend <= 1'b0;
            if (w_timeout) begin
                r_mem_err <= 1'b1;
            end
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= idex_bubble ? SLOT_EMPTY : w_id_slot;
        end
    end

    fwd_select u_fwd_a (
        .i_src    (id_rn),
        .i_ex_wr  (r_ex.valid & r_ex.wr),
        .i_ex_rd  (r_ex.rd),
        .i_mem_wr (r_mem.valid & r_mem.wr),
        .i_mem_rd (r_mem.rd),
        .i_wb_wr  (r_wb.valid & r_wb.wr),
        .i_wb_rd  (r_wb.rd),
        .o_sel    (fwd_a)
    );

    fwd_select u_fwd_b (
        .i_src    (id_rm),
        .i_ex_wr  (r_ex.valid & r_ex.wr),
        .i_ex_rd  (r_ex.rd),
        .i_mem_wr (r_mem.valid & r_mem.wr),
        .i_mem_rd (r_mem.rd),
        .i_wb_wr  (r_wb.valid & r_wb.wr),
        .i_wb_rd  (r_wb.rd),
        .o_sel    (fwd_b)
    );

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: directed vector table, multi-cycle memory
// wait / timeout / reset sequences, then random traffic against a model.
module tb_pipeline_sequencer;

    localparam int TMO = 15;

    typedef struct packed {
        logic       v;
        logic [3:0] rn;
        logic [3:0] rm;
        logic [3:0] rd;
        logic       urn;
        logic       urm;
        logic       rf;
        logic       ld;
        logic       me;
        logic       bt;
        logic       rdy;
    } in_t;

    typedef struct packed {
        logic       pc;
        logic       ifid;
        logic       idex;
        logic       exm;
        logic       fl;
        logic       bub;
        logic       mreq;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       err;
    } out_t;

    typedef struct {
        in_t  in;
        out_t exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       id_valid;
    logic [3:0] id_rn, id_rm, id_rd;
    logic       id_uses_rn, id_uses_rm;
    logic       id_rf_enable, id_load_instr, id_mem_enable;
    logic       ex_branch_taken;
    logic       mem_ready;
    logic       pc_enable, ifid_enable, idex_enable, exmem_enable;
    logic       ifid_flush, idex_bubble, mem_req, mem_err;
    logic [1:0] fwd_a, fwd_b;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: index 0 = EX, 1 = MEM, 2 = WB
    bit         m_v[3];
    logic [3:0] m_rd[3];
    bit         m_wr[3];
    bit         m_ld[3];
    bit         m_me[3];
    int         m_wait;
    bit         m_pend;
    bit         m_err;

    always #5 clk = ~clk;

    pipeline_sequencer #(.MEM_TIMEOUT(TMO)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .id_valid        (id_valid),
        .id_rn           (id_rn),
        .id_rm           (id_rm),
        .id_rd           (id_rd),
        .id_uses_rn      (id_uses_rn),
        .id_uses_rm      (id_uses_rm),
        .id_rf_enable    (id_rf_enable),
        .id_load_instr   (id_load_instr),
        .id_mem_enable   (id_mem_enable),
        .ex_branch_taken (ex_branch_taken),
        .mem_ready       (mem_ready),
        .pc_enable       (pc_enable),
        .ifid_enable     (ifid_enable),
        .idex_enable     (idex_enable),
        .exmem_enable    (exmem_enable),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .mem_req         (mem_req),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .mem_err         (mem_err)
    );

    function automatic in_t mk(logic v, logic [3:0] rn, logic [3:0] rm, logic [3:0] rd,
                               logic urn, logic urm, logic rf, logic ld, logic me,
                               logic bt, logic rdy);
        in_t r;
        r = '{v, rn, rm, rd, urn, urm, rf, ld, me, bt, rdy};
        return r;
    endfunction

    function automatic out_t eo(logic pc, logic ifid, logic idex, logic exm, logic fl,
                                logic bub, logic mreq, logic [1:0] fa, logic [1:0] fb,
                                logic err);
        out_t r;
        r = '{pc, ifid, idex, exm, fl, bub, mreq, fa, fb, err};
        return r;
    endfunction

    function automatic logic [1:0] model_fwd(logic [3:0] src);
        if (src == 4'd15) return 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (m_v[k] && m_wr[k] && m_rd[k] == src) return 2'(k + 1);
        end
        return 2'd0;
    endfunction

    function automatic out_t model_out(in_t in);
        out_t o;
        bit   mreq, tmo, frz, br, lu;
        mreq = m_v[1] && m_me[1];
        tmo  = mreq && (m_wait >= TMO);
        frz  = mreq && !in.rdy && !tmo;
        br   = !frz && (in.bt || m_pend);
        lu   = !frz && !br && in.v && m_v[0] && m_ld[0] &&
               ((in.urn && in.rn == m_rd[0]) || (in.urm && in.rm == m_rd[0]));
        o.pc   = !frz && !lu;
        o.ifid = !frz && !lu;
        o.idex = !frz;
        o.exm  = !frz;
        o.fl   = br;
        o.bub  = br || lu;
        o.mreq = mreq;
        o.fa   = model_fwd(in.rn);
        o.fb   = model_fwd(in.rm);
        o.err  = m_err;
        return o;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_v[k] = 0; m_rd[k] = '0; m_wr[k] = 0; m_ld[k] = 0; m_me[k] = 0;
        end
        m_wait = 0;
        m_pend = 0;
        m_err  = 0;
    endtask

    task automatic model_step(in_t in);
        out_t o;
        o = model_out(in);
        if (!o.idex) begin
            m_wait++;
            m_pend = m_pend || in.bt;
        end else begin
            if (o.mreq && m_wait >= TMO) m_err = 1;
            m_wait = 0;
            m_pend = 0;
            for (int k = 2; k > 0; k--) begin
                m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_wr[k] = m_wr[k-1];
                m_ld[k] = m_ld[k-1]; m_me[k] = m_me[k-1];
            end
            m_v[0]  = in.v && !o.bub;
            m_rd[0] = in.rd;
            m_wr[0] = in.rf;
            m_ld[0] = in.ld;
            m_me[0] = in.me;
        end
    endtask

    task automatic drive(in_t in);
        id_valid        = in.v;
        id_rn           = in.rn;
        id_rm           = in.rm;
        id_rd           = in.rd;
        id_uses_rn      = in.urn;
        id_uses_rm      = in.urm;
        id_rf_enable    = in.rf;
        id_load_instr   = in.ld;
        id_mem_enable   = in.me;
        ex_branch_taken = in.bt;
        mem_ready       = in.rdy;
    endtask

    task automatic check(string name, out_t exp);
        out_t act;
        act = {pc_enable, ifid_enable, idex_enable, exmem_enable, ifid_flush,
               idex_bubble, mem_req, fwd_a, fwd_b, mem_err};
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b [pc ifid idex exmem flush bubble memreq fwda fwdb err]",
                     name, act, exp);
        end
    endtask

    // One clock: drive at the falling edge, sample 1ns later, step the model.
    task automatic cycle(in_t in, out_t exp, string name);
        @(negedge clk);
        drive(in);
        #1;
        check(name, exp);
        model_step(in);
    endtask

    task automatic model_cycle(in_t in, string name);
        out_t exp;
        @(negedge clk);
        drive(in);
        #1;
        exp = model_out(in);
        check(name, exp);
        model_step(in);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        reset_n = 1'b0;
        model_reset();
        #2;
        check("reset_hold", eo(1, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    vec_t  tbl[11];
    in_t   idle_lo, idle_hi, str_in;
    out_t  run_o, frz_o;

    function automatic logic [3:0] rand_reg();
        int unsigned r;
        r = $urandom_range(0, 7);
        if (r < 4) return 4'(r);
        if (r == 4) return 4'd15;
        return 4'($urandom_range(0, 15));
    endfunction

    initial begin
        in_t         rin;
        int unsigned burst;

        reset_n = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        model_reset();

        tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), eo(1, 1, 1, 1, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{mk(1, 5, 0, 1, 1, 0, 1, 1, 1, 0, 1), eo(1, 1, 1, 1, 0, 0, 0, 0, 0, 0)};
        tbl[2]  = '{mk(1, 1, 3, 2, 1, 1, 1, 0, 0, 0, 1), eo(0, 0, 1, 1, 0, 1, 0, 1, 0, 0)};
        tbl[3]  = '{mk(1, 1, 3, 2, 1, 1, 1, 0, 0, 0, 1), eo(1, 1, 1, 1, 0, 0, 1, 2, 0, 0)};
        tbl[4]  = '{mk(1, 5, 6, 1, 1, 1, 1, 0, 0, 0, 1), eo(1, 1, 1, 1, 0, 0, 0, 0, 0, 0)};
        tbl[5]  = '{mk(1, 1, 1, 4, 1, 1, 1, 0, 0, 0, 1), eo(1, 1, 1, 1, 0, 0, 0, 1, 1, 0)};
        tbl[6]  = '{mk(1, 2, 15, 15, 1, 1, 1, 0, 0, 0, 1), eo(1, 1, 1, 1, 0, 0, 0, 3, 0, 0)};
        tbl[7]  = '{mk(1, 15, 1, 3, 1, 1, 0, 0, 0, 0, 1), eo(1, 1, 1, 1, 0, 0, 0, 0, 3, 0)};
        tbl[8]  = '{mk(1, 4, 0, 7, 1, 0, 1, 1, 1, 0, 1), eo(1, 1, 1, 1, 0, 0, 0, 3, 0, 0)};
        tbl[9]  = '{mk(1, 7, 0, 8, 1, 0, 1, 0, 0, 1, 1), eo(1, 1, 1, 1, 1, 1, 0, 1, 0, 0)};
        tbl[10] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), eo(1, 1, 1, 1, 0, 0, 1, 0, 0, 0)};

        idle_hi = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle_lo = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        str_in  = mk(1, 2, 0, 9, 1, 0, 0, 0, 1, 0, 1);
        run_o   = eo(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        frz_o   = eo(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        #2;
        check("reset_hold", run_o);
        @(negedge clk);
        reset_n = 1'b1;

        for (int unsigned i = 0; i < 11; i++) begin
            cycle(tbl[i].in, tbl[i].exp, $sformatf("table[%0d]", i));
        end

        // Store waits three cycles; a branch seen while frozen acts on release
        cycle(str_in, run_o, "wait3_str");
        cycle(idle_hi, run_o, "wait3_idle");
        cycle(idle_lo, frz_o, "wait3_frz1");
        cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), frz_o, "wait3_frz2_branch");
        cycle(idle_lo, frz_o, "wait3_frz3");
        cycle(idle_hi, eo(1, 1, 1, 1, 1, 1, 1, 0, 0, 0), "wait3_release");
        cycle(idle_hi, run_o, "wait3_after");

        // mem_ready stuck low: timeout after TMO wait cycles, sticky mem_err
        cycle(str_in, run_o, "tmo_str");
        cycle(idle_hi, run_o, "tmo_idle");
        for (int unsigned i = 0; i < TMO; i++) begin
            cycle(idle_lo, frz_o, $sformatf("tmo_frz[%0d]", i));
        end
        cycle(idle_lo, eo(1, 1, 1, 1, 0, 0, 1, 0, 0, 0), "tmo_release");
        cycle(idle_lo, eo(1, 1, 1, 1, 0, 0, 0, 0, 0, 1), "tmo_err_set");
        cycle(idle_hi, eo(1, 1, 1, 1, 0, 0, 0, 0, 0, 1), "tmo_err_sticky");

        // Reset pulse in the middle of a memory wait
        cycle(str_in, eo(1, 1, 1, 1, 0, 0, 0, 0, 0, 1), "rst_str");
        cycle(idle_hi, eo(1, 1, 1, 1, 0, 0, 0, 0, 0, 1), "rst_idle");
        for (int unsigned i = 0; i < 3; i++) begin
            cycle(idle_lo, eo(0, 0, 0, 0, 0, 0, 1, 0, 0, 1), $sformatf("rst_frz[%0d]", i));
        end
        @(negedge clk);
        drive(idle_lo);
        #1 reset_n = 1'b0;
        #1 check("rst_async", run_o);
        #1 reset_n = 1'b1;
        model_reset();
        cycle(idle_lo, run_o, "rst_after");

        // Random traffic against the reference model
        do_reset();
        burst = 0;
        for (int unsigned i = 0; i < 4000; i++) begin
            rin.v   = ($urandom_range(0, 4) != 0);
            rin.rn  = rand_reg();
            rin.rm  = rand_reg();
            rin.rd  = rand_reg();
            rin.urn = $urandom_range(0, 1);
            rin.urm = $urandom_range(0, 1);
            rin.rf  = $urandom_range(0, 1);
            rin.ld  = ($urandom_range(0, 2) == 0);
            rin.me  = rin.ld || ($urandom_range(0, 3) == 0);
            rin.bt  = ($urandom_range(0, 7) == 0);
            if (burst > 0) begin
                rin.rdy = 1'b0;
                burst--;
            end else if ($urandom_range(0, 39) == 0) begin
                burst   = $urandom_range(10, 20);
                rin.rdy = 1'b0;
            end else begin
                rin.rdy = ($urandom_range(0, 3) != 0);
            end
            model_cycle(rin, $sformatf("rand[%0d]", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
